// File: rtl/fifo_uart_drain_if.sv
// FIFO-to-drain handshake: the FIFO presents its head word and empty flag, the drain answers with a pop strobe.
interface fifo_uart_drain_if #(
  parameter int unsigned bitWidth = 32
);
  logic                fifoEmpty;
  logic [bitWidth-1:0] fifoPopData;
  logic                fifoPop;

  modport master (output fifoEmpty, output fifoPopData, input fifoPop);
  modport slave  (input fifoEmpty, input fifoPopData, output fifoPop);
endinterface

// File: rtl/fifo_uart_drain.sv
// Pops FIFO words and serialises them LSB byte first as 8N1 UART frames on txd.
module fifo_uart_drain #(
  parameter int unsigned bitWidth    = 32,
  parameter int unsigned baudDivisor = 868
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  fifo_uart_drain_if.slave   fifo,
  output logic               txd,
  output logic               busy
);
  localparam int unsigned NR_BYTES = bitWidth / 8;
  localparam int unsigned BYTE_W   = (NR_BYTES > 1) ? $clog2(NR_BYTES) : 1;
  localparam int unsigned BAUD_W   = $clog2(baudDivisor);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(baudDivisor - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NR_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_next;
  logic [bitWidth-1:0] word, word_next;
  logic [BYTE_W-1:0]   byte_cnt, byte_next;
  logic [2:0]          bit_cnt, bit_next;
  logic [BAUD_W-1:0]   baud_cnt, baud_next;
  logic                baud_end;
  logic                pop_req;
  logic                txd_next;

  assign baud_end     = (baud_cnt == BAUD_LAST);
  assign fifo.fifoPop = pop_req & ~reset;

  always_comb begin
    state_next = state;
    word_next  = word;
    byte_next  = byte_cnt;
    bit_next   = bit_cnt;
    baud_next  = baud_cnt;
    pop_req    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && !fifo.fifoEmpty) begin
          pop_req    = 1'b1;
          word_next  = fifo.fifoPopData;
          byte_next  = '0;
          bit_next   = '0;
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next = '0;
          word_next = word >> 1;
          bit_next  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = STOP;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_next = '0;
          // word has already been shifted 8 places, so the next byte sits in word[7:0]
          if (byte_cnt == BYTE_LAST) begin
            state_next = IDLE;
          end else begin
            byte_next  = byte_cnt + 1'b1;
            state_next = START;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // txd is registered, so it is derived from the state being entered
    unique case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = word_next[0];
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      word     <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      word     <= word_next;
      byte_cnt <= byte_next;
      bit_cnt  <= bit_next;
      baud_cnt <= baud_next;
      txd      <= txd_next;
      busy     <= (state_next != IDLE);
    end
  end
endmodule
